expr_host: RTL and testbench
============================

EXPR_HOST -- requirements
Module: expr_host

Interface
REQ-001 Parameter W, default 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 32, maximum solver wait in cycles (used only with EXPR_HOST_TIMEOUT_EN).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  host accepts operand set this cycle.
REQ-007 in_x, in_a, in_b  input  W each  operands of one job.
REQ-008 slv_rst  output  1  synchronous-pulse reset to solver control FSM.
REQ-009 slv_start  output  1  start pulse to solver.
REQ-010 slv_x, slv_a, slv_b  output  W each  registered operands driven to solver datapath.
REQ-011 slv_completed  input  1  solver done flag; stays high until solver reset.
REQ-012 slv_result  input  W  solver result, valid while slv_completed=1.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_result  output  W  captured result.
REQ-016 out_timeout  output  1  job aborted by timeout; qualified by out_valid.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, LAUNCH, WAIT, HOLD, encoded in 3 bits; unused codes go to IDLE.
REQ-019 IDLE: in_ready=1; on in_valid=1, operands SHALL be registered into slv_x/a/b and state SHALL go to CLEAR.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid in any other state SHALL be ignored and operands not sampled.
REQ-021 CLEAR: slv_rst=1 for exactly one cycle, then LAUNCH.
REQ-022 LAUNCH: slv_start=1 for exactly one cycle, then WAIT; timeout counter cleared.
REQ-023 WAIT: on first cycle with slv_completed=1, slv_result SHALL be captured into out_result, out_timeout=0, state to HOLD.
REQ-024 slv_completed=1 seen in CLEAR or LAUNCH (stale from prior job) SHALL be ignored.
REQ-025 HOLD: out_valid=1, out_result/out_timeout stable; on out_ready=1 state SHALL go to IDLE with out_valid=0 next cycle.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 slv_start and slv_rst SHALL never be high in the same cycle.
REQ-028 Latency in_valid accept -> out_valid SHALL be 3 cycles + solver latency (cycles from slv_start sampled to slv_completed high).
REQ-029 Back-to-back: in_valid held high SHALL be accepted in the IDLE cycle immediately following HOLD exit; every job begins with CLEAR.

Reset
REQ-030 rst=1 SHALL force, asynchronously: state IDLE, in_ready=1 after release, slv_rst=1 while rst asserted, slv_start=0, slv_x/a/b=0, out_valid=0, out_result=0, out_timeout=0, busy=0, counter=0.
REQ-031 rst mid-job (any state) SHALL abandon the job with no out_valid; the next job SHALL proceed normally through CLEAR.

Configuration
REQ-032 Macro EXPR_HOST_TIMEOUT_EN defined: WAIT counts cycles; when count reaches TIMEOUT without slv_completed, state SHALL go to HOLD with out_result=0, out_timeout=1; slv_completed in that same cycle SHALL take priority (normal capture).
REQ-033 Macro not defined: no counter logic; WAIT waits indefinitely; out_timeout tied 0.

Verification
REQ-034 Reset then in_valid=1, x=3,a=2,b=5; solver model completes 7 cycles after start with result 0x11 -> slv_rst one cycle, slv_start one cycle, out_valid with out_result=0x11, out_timeout=0.
REQ-035 out_ready held 0 for 10 cycles in HOLD -> out_valid and out_result=0x11 stable, in_ready=0, second in_valid ignored.
REQ-036 Two jobs back-to-back with in_valid and out_ready tied 1 -> two results in order, each job preceded by slv_rst pulse, stale completed not captured.
REQ-037 With EXPR_HOST_TIMEOUT_EN, TIMEOUT=32, solver never completes -> out_valid exactly 32 cycles after entering WAIT, out_timeout=1, out_result=0.
REQ-038 rst asserted during WAIT -> all outputs at reset values immediately, no out_valid; subsequent job x=1,a=1,b=1 completes normally.

Source files
------------

// File: rtl/expr_host_if.sv
// expr_host_if -- bundle of every handshake and solver signal around expr_host.
//
// Parameter:
//   W  operand/result width in bits.
//
// Signal groups:
//   in_*   job intake:   in_valid/in_ready handshake plus operands in_x, in_a, in_b.
//   slv_*  solver link:  slv_rst/slv_start control pulses, registered operands slv_x/a/b,
//                        solver status slv_completed and data slv_result.
//   out_*  result side:  out_valid/out_ready handshake, out_result, out_timeout.
//   busy   host is inside a job (any state but idle).
//
// Modports:
//   slave   the host itself: consumes jobs, drives the solver, produces results.
//   master  the surroundings: job source, solver datapath and result consumer.

interface expr_host_if #(
  parameter int unsigned W = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  logic         slv_rst;
  logic         slv_start;
  logic [W-1:0] slv_x;
  logic [W-1:0] slv_a;
  logic [W-1:0] slv_b;
  logic         slv_completed;
  logic [W-1:0] slv_result;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_timeout;

  logic         busy;

  modport slave (
    input  in_valid, in_x, in_a, in_b,
    input  slv_completed, slv_result,
    input  out_ready,
    output in_ready,
    output slv_rst, slv_start, slv_x, slv_a, slv_b,
    output out_valid, out_result, out_timeout,
    output busy
  );

  modport master (
    output in_valid, in_x, in_a, in_b,
    output slv_completed, slv_result,
    output out_ready,
    input  in_ready,
    input  slv_rst, slv_start, slv_x, slv_a, slv_b,
    input  out_valid, out_result, out_timeout,
    input  busy
  );

endinterface

// File: rtl/expr_host.sv
// expr_host -- sequencer that feeds one operand set at a time to an external solver.
//
// A job is accepted in idle, the solver control is cleared with a one-cycle slv_rst,
// started with a one-cycle slv_start, and the host then waits for slv_completed. The
// solver result is held on out_result with out_valid until the consumer takes it.
//
// Parameters:
//   W        operand/result width in bits.
//   TIMEOUT  wait limit in cycles; only used when EXPR_HOST_TIMEOUT_EN is defined.
//
// Optional feature (macro EXPR_HOST_TIMEOUT_EN):
//   Defined   -> the wait state counts cycles and aborts after TIMEOUT cycles with
//                out_result = 0 and out_timeout = 1.
//   Undefined -> no counter; the host waits indefinitely and out_timeout is tied low.
//
// Ports:
//   clk  rising-edge clock.
//   rst  asynchronous, active-high reset.
//   bus  expr_host_if slave modport carrying the job, solver and result signals.
//
// Every output is a flop. The output flops are loaded from a decode of the next state,
// so they change together with the state register and never glitch.

module expr_host #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  expr_host_if.slave bus
);

  // A zero limit would expire before the solver could ever answer.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("expr_host: TIMEOUT must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StLaunch = 3'd2,
    StWait   = 3'd3,
    StHold   = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic         slv_rst_q, slv_rst_d;
  logic         slv_start_q, slv_start_d;
  logic [W-1:0] slv_x_q, slv_x_d;
  logic [W-1:0] slv_a_q, slv_a_d;
  logic [W-1:0] slv_b_q, slv_b_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;

`ifdef EXPR_HOST_TIMEOUT_EN
  // Counts completed wait cycles; it only has to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_timeout_q, out_timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    slv_x_d      = slv_x_q;
    slv_a_d      = slv_a_q;
    slv_b_d      = slv_b_q;
    out_result_d = out_result_q;
`ifdef EXPR_HOST_TIMEOUT_EN
    cnt_d         = cnt_q;
    out_timeout_d = out_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          slv_x_d = bus.in_x;
          slv_a_d = bus.in_a;
          slv_b_d = bus.in_b;
          state_d = StClear;
        end
      end

      // slv_completed may still be high from the previous job here and in StLaunch;
      // it is only looked at in StWait, after the solver has been cleared.
      StClear: begin
        state_d = StLaunch;
      end

      StLaunch: begin
        state_d = StWait;
`ifdef EXPR_HOST_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      StWait: begin
        // A completion arriving in the same cycle as the timeout wins.
        if (bus.slv_completed) begin
          out_result_d = bus.slv_result;
          state_d      = StHold;
`ifdef EXPR_HOST_TIMEOUT_EN
          out_timeout_d = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          out_result_d  = '0;
          out_timeout_d = 1'b1;
          state_d       = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end

      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered outputs follow the state being entered.
    in_ready_d  = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    slv_rst_d   = (state_d == StClear);
    slv_start_d = (state_d == StLaunch);
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      // The solver control is held in reset for as long as the host is.
      slv_rst_q    <= 1'b1;
      slv_start_q  <= 1'b0;
      slv_x_q      <= '0;
      slv_a_q      <= '0;
      slv_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef EXPR_HOST_TIMEOUT_EN
      cnt_q         <= '0;
      out_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      slv_rst_q    <= slv_rst_d;
      slv_start_q  <= slv_start_d;
      slv_x_q      <= slv_x_d;
      slv_a_q      <= slv_a_d;
      slv_b_q      <= slv_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
`ifdef EXPR_HOST_TIMEOUT_EN
      cnt_q         <= cnt_d;
      out_timeout_q <= out_timeout_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.slv_rst    = slv_rst_q;
  assign bus.slv_start  = slv_start_q;
  assign bus.slv_x      = slv_x_q;
  assign bus.slv_a      = slv_a_q;
  assign bus.slv_b      = slv_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
`ifdef EXPR_HOST_TIMEOUT_EN
  assign bus.out_timeout = out_timeout_q;
`else
  assign bus.out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_expr_host.sv
// tb_expr_host -- self-checking bench for expr_host.
//
// A behavioural solver answers sol_lat cycles after it samples slv_start with
// a*x + b + 6 computed from the operands it was handed, and keeps slv_completed high
// until slv_rst. Expected results are queued when a job is driven; a monitor queues
// every out_valid/out_ready handshake, and the tests pop and compare the two.

module tb_expr_host;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  expr_host_if #(.W(W)) bus ();

  expr_host #(
    .W       (W),
    .TIMEOUT (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [W:0] exp_q[$];  // {timeout, result}
  logic [W:0] got_q[$];

  int n_rst_pulse = 0;
  int n_start     = 0;
  int n_overlap   = 0;

  // Solver model.
  int sol_lat   = 7;
  bit sol_never = 1'b0;
  int sol_rem;
  bit sol_run;

  function automatic logic [W-1:0] sol_f(input logic [W-1:0] x, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    return a * x + b + W'(6);
  endfunction

  always @(posedge clk) begin
    if (bus.slv_rst) begin
      bus.slv_completed <= 1'b0;
      sol_run           <= 1'b0;
    end else if (bus.slv_start) begin
      sol_run        <= !sol_never;
      sol_rem        <= sol_lat - 1;
      bus.slv_result <= sol_f(bus.slv_x, bus.slv_a, bus.slv_b);
    end else if (sol_run) begin
      if (sol_rem == 0) begin
        bus.slv_completed <= 1'b1;
        sol_run           <= 1'b0;
      end else begin
        sol_rem <= sol_rem - 1;
      end
    end
  end

  // Monitor, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.slv_rst) n_rst_pulse++;
      if (bus.slv_start) n_start++;
      if (bus.slv_rst && bus.slv_start) n_overlap++;
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_timeout, bus.out_result});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) step();
    n_vec++;
    if (bus.slv_rst !== 1'b1) begin
      n_fail++; $display("FAIL reset_slv_rst: got %b want 1", bus.slv_rst);
    end
    n_vec++;
    if ({bus.slv_start, bus.busy, bus.out_valid, bus.out_timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got start/busy/valid/tmo=%b want 0000",
               {bus.slv_start, bus.busy, bus.out_valid, bus.out_timeout});
    end
    n_vec++;
    if ({bus.slv_x, bus.slv_a, bus.slv_b, bus.out_result} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got x/a/b/res=%h/%h/%h/%h want 0", bus.slv_x, bus.slv_a,
               bus.slv_b, bus.out_result);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({bus.in_ready, bus.slv_rst, bus.busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got ready/slv_rst/busy=%b want 100",
               {bus.in_ready, bus.slv_rst, bus.busy});
    end
  endtask

  task automatic test_single();
    int r0 = n_rst_pulse;
    int s0 = n_start;
    int k  = 0;
    sol_lat   = 7;
    sol_never = 1'b0;
    bus.in_x = 8'd3; bus.in_a = 8'd2; bus.in_b = 8'd5;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b0, sol_f(8'd3, 8'd2, 8'd5)});
    step();
    bus.in_valid = 1'b0;
    n_vec++;
    if ({bus.slv_x, bus.slv_a, bus.slv_b} !== {8'd3, 8'd2, 8'd5}) begin
      n_fail++;
      $display("FAIL single_operands: got %h/%h/%h want 03/02/05", bus.slv_x, bus.slv_a,
               bus.slv_b);
    end
    n_vec++;
    if ({bus.busy, bus.in_ready, bus.slv_rst, bus.slv_start} !== 4'b1010) begin
      n_fail++;
      $display("FAIL single_clear: got busy/ready/rst/start=%b want 1010",
               {bus.busy, bus.in_ready, bus.slv_rst, bus.slv_start});
    end
    while (!bus.out_valid && k < 60) begin
      step();
      k++;
    end
    n_vec++;
    if (k !== 10) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles want 10", k);
    end
    n_vec++;
    if ({bus.out_timeout, bus.out_result} !== {1'b0, 8'h11}) begin
      n_fail++;
      $display("FAIL single_result: got tmo=%b res=%h want tmo=0 res=11", bus.out_timeout,
               bus.out_result);
    end
    n_vec++;
    if ((n_rst_pulse - r0) !== 1 || (n_start - s0) !== 1 || n_overlap !== 0) begin
      n_fail++;
      $display("FAIL single_pulses: got rst=%0d start=%0d overlap=%0d want 1/1/0",
               n_rst_pulse - r0, n_start - s0, n_overlap);
    end
  endtask

  task automatic test_hold();
    int r0 = n_rst_pulse;
    logic [W:0] g, e;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x = 8'd9; bus.in_a = 8'd9; bus.in_b = 8'd9;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({bus.out_valid, bus.in_ready, bus.out_result, bus.slv_x} !== {1'b1, 1'b0, 8'h11, 8'd3})
      begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b ready=%b res=%h slv_x=%h want 1/0/11/03",
                 i, bus.out_valid, bus.in_ready, bus.out_result, bus.slv_x);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL hold_exit: got valid/ready/busy=%b want 010",
               {bus.out_valid, bus.in_ready, bus.busy});
    end
    n_vec++;
    if (n_rst_pulse !== r0) begin
      n_fail++; $display("FAIL hold_no_new_job: got %0d extra slv_rst want 0", n_rst_pulse - r0);
    end
    n_vec++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL hold_scoreboard: got %0d results want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++; $display("FAIL hold_scoreboard: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int r0 = n_rst_pulse;
    int s0 = n_start;
    int k;
    logic [W-1:0] ops[2][3] = '{'{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd3, 8'd2}};
    logic [W:0] g, e;
    sol_lat = 3;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      bus.in_x = ops[j][0]; bus.in_a = ops[j][1]; bus.in_b = ops[j][2];
      bus.in_valid = 1'b1;
      exp_q.push_back({1'b0, sol_f(ops[j][0], ops[j][1], ops[j][2])});
      k = 0;
      while (!bus.in_ready && k < 40) begin
        step();
        k++;
      end
      if (j == 1) begin
        n_vec++;
        if (k !== 7) begin
          n_fail++; $display("FAIL b2b_gap: got %0d cycles to re-accept want 7", k);
        end
      end
      step();
    end
    bus.in_valid = 1'b0;
    k = 0;
    while (got_q.size() < 2 && k < 60) begin
      step();
      k++;
    end
    bus.out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      n_vec++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got none want a result", j);
      end else begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", j, g, e);
        end
      end
    end
    n_vec++;
    if ((n_rst_pulse - r0) !== 2 || (n_start - s0) !== 2 || n_overlap !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: got rst=%0d start=%0d overlap=%0d want 2/2/0",
               n_rst_pulse - r0, n_start - s0, n_overlap);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    int k;
    int seen_valid = 0;
    logic [W:0] g, e;
    sol_lat = 20;
    bus.in_x = 8'd10; bus.in_a = 8'd2; bus.in_b = 8'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.busy, bus.out_valid, bus.slv_start, bus.slv_rst, bus.in_ready} !== 5'b00011) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got busy/valid/start/rst/ready=%b want 00011",
               {bus.busy, bus.out_valid, bus.slv_start, bus.slv_rst, bus.in_ready});
    end
    n_vec++;
    if ({bus.slv_x, bus.slv_a, bus.slv_b, bus.out_result, bus.out_timeout} !== '0) begin
      n_fail++;
      $display("FAIL midrst_data: got x/a/b/res/tmo=%h/%h/%h/%h/%b want 0", bus.slv_x,
               bus.slv_a, bus.slv_b, bus.out_result, bus.out_timeout);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid) seen_valid++;
    end
    n_vec++;
    if (seen_valid !== 0 || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrst_abandon: got %0d valid cycles, %0d results want 0/0", seen_valid,
               got_q.size());
    end
    r0 = n_rst_pulse;
    sol_lat = 2;
    bus.in_x = 8'd1; bus.in_a = 8'd1; bus.in_b = 8'd1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, sol_f(8'd1, 8'd1, 8'd1)});
    step();
    bus.in_valid = 1'b0;
    k = 0;
    while (got_q.size() < 1 && k < 40) begin
      step();
      k++;
    end
    bus.out_ready = 1'b0;
    n_vec++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL midrst_next_job: got no result want %h", {1'b0, 8'd8});
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++; $display("FAIL midrst_next_job: got %h want %h", g, e);
      end
    end
    n_vec++;
    if ((n_rst_pulse - r0) !== 1) begin
      n_fail++; $display("FAIL midrst_clear: got %0d slv_rst cycles want 1", n_rst_pulse - r0);
    end
  endtask

`ifdef EXPR_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    logic [W:0] g, e;
    sol_never = 1'b1;
    bus.in_x = 8'd5; bus.in_a = 8'd5; bus.in_b = 8'd5;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b1, 8'd0});
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();  // now in the first wait cycle
    while (!bus.out_valid && k < 100) begin
      step();
      k++;
    end
    n_vec++;
    if (k !== 32) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles want 32", k);
    end
    n_vec++;
    if ({bus.out_timeout, bus.out_result} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL timeout_result: got tmo=%b res=%h want tmo=1 res=00", bus.out_timeout,
               bus.out_result);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_vec++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL timeout_scoreboard: got no result want %h", {1'b1, 8'd0});
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      if (g !== e) begin
        n_fail++; $display("FAIL timeout_scoreboard: got %h want %h", g, e);
      end
    end
    sol_never = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef EXPR_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
